// File: rtl/branch_pkg.sv
// Shared types and constants for the decode-stage branch resolver.
// Latency: n/a (types, constants and one pure function only).
// Backpressure: n/a.
//
// Contents: opcode match patterns (casez, '?' = don't care), ARM condition
// code enum, 2-bit BHT counter type and its reset value, and the condition
// evaluation helper used by the top level.
package branch_pkg;

   localparam logic [10:0] OP_B     = 11'b000101?????;
   localparam logic [10:0] OP_BL    = 11'b100101?????;
   localparam logic [10:0] OP_BCOND = 11'b01010100???;
   localparam logic [10:0] OP_CBZ   = 11'b10110100???;
   localparam logic [10:0] OP_CBNZ  = 11'b10110101???;
   localparam logic [10:0] OP_BR    = 11'b11010110000;

   typedef enum logic [3:0] {
      COND_EQ = 4'b0000,
      COND_NE = 4'b0001,
      COND_HS = 4'b0010,
      COND_LO = 4'b0011,
      COND_MI = 4'b0100,
      COND_PL = 4'b0101,
      COND_GE = 4'b1010,
      COND_LT = 4'b1011,
      COND_GT = 4'b1100,
      COND_LE = 4'b1101,
      COND_AL = 4'b1110
   } cond_e;

   typedef logic [1:0] bht_cnt_t;

   localparam bht_cnt_t WEAK_NT = 2'b01;

   // Codes outside the enumerated set (VS/VC/HI/LS/NV) are never taken.
   function automatic logic cond_holds(input logic [3:0] cond,
                                       input logic n, input logic z,
                                       input logic c, input logic v);
      logic hit;
      hit = 1'b0;
      case (cond_e'(cond))
         COND_EQ: hit = z;
         COND_NE: hit = !z;
         COND_HS: hit = c;
         COND_LO: hit = !c;
         COND_MI: hit = n;
         COND_PL: hit = !n;
         COND_GE: hit = (n == v);
         COND_LT: hit = (n != v);
         COND_GT: hit = !z && (n == v);
         COND_LE: hit = z || (n != v);
         COND_AL: hit = 1'b1;
         default: hit = 1'b0;
      endcase
      return hit;
   endfunction

endpackage

// File: rtl/branch_hist_table.sv
// Bimodal branch history table of 2-bit saturating counters.
// Latency: read is combinational; a write is visible on the next cycle.
// Backpressure: none; the caller qualifies wr_en_i.
//
// Ports: clk_i/reset_i (sync, active-high, all entries -> WEAK_NT),
//        rd_idx_i -> rd_cnt_o (read), wr_en_i/wr_idx_i/wr_taken_i (update).
// A read and write of the same index in one cycle returns the old value.
module branch_hist_table
   import branch_pkg::*;
#(
   parameter int DEPTH = 64,
   parameter int IDX_W = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic [IDX_W-1:0] rd_idx_i,
   output bht_cnt_t         rd_cnt_o,
   input  logic             wr_en_i,
   input  logic [IDX_W-1:0] wr_idx_i,
   input  logic             wr_taken_i
);

   bht_cnt_t cnt_q [DEPTH];
   bht_cnt_t cur;
   bht_cnt_t cnt_d;

   assign rd_cnt_o = cnt_q[rd_idx_i];

   always_comb begin
      cur   = cnt_q[wr_idx_i];
      cnt_d = cur;
      if (wr_taken_i) begin
         if (cur != 2'b11) cnt_d = cur + 2'd1;
      end else begin
         if (cur != 2'b00) cnt_d = cur - 2'd1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         for (int i = 0; i < DEPTH; i++) cnt_q[i] <= WEAK_NT;
      end else if (wr_en_i) begin
         cnt_q[wr_idx_i] <= cnt_d;
      end
   end

endmodule

// File: rtl/branch_predict_unit.sv
// Decode-stage branch resolver with bimodal prediction and perf counters.
// Latency: decode/resolve outputs combinational; BHT and counters update next cycle.
// Backpressure: stall_i holds the fetch->decode pipe and suppresses resolves.
//
// Ports: clk_i, reset_i (sync, active-high), stall_i, flush_i, fetch_pc_i ->
//        pred_taken_o; dec_valid_i, opcode_i, cond_i, flag_wr_en_i, flag_*_i,
//        alu_*_i, regVal_in_i -> BrTaken_o, UncondBr_o, pc_rd_o, mispredict_o;
//        br_count_o, mispred_count_o (saturating).
module branch_predict_unit
   import branch_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int PC_WIDTH   = 64,
   parameter int BHT_DEPTH  = 64,
   parameter int IDX_LSB    = 2,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk_i,
   input  logic                  reset_i,
   input  logic                  stall_i,
   input  logic                  flush_i,
   input  logic [PC_WIDTH-1:0]   fetch_pc_i,
   output logic                  pred_taken_o,
   input  logic                  dec_valid_i,
   input  logic [10:0]           opcode_i,
   input  logic [3:0]            cond_i,
   input  logic                  flag_wr_en_i,
   input  logic                  flag_neg_i,
   input  logic                  flag_zero_i,
   input  logic                  flag_overf_i,
   input  logic                  flag_cOut_i,
   input  logic                  alu_neg_i,
   input  logic                  alu_zero_i,
   input  logic                  alu_overf_i,
   input  logic                  alu_cOut_i,
   input  logic [DATA_WIDTH-1:0] regVal_in_i,
   output logic                  BrTaken_o,
   output logic                  UncondBr_o,
   output logic                  pc_rd_o,
   output logic                  mispredict_o,
   output logic [CNT_WIDTH-1:0]  br_count_o,
   output logic [CNT_WIDTH-1:0]  mispred_count_o
);

   localparam int IDX_W = $clog2(BHT_DEPTH);

   logic [IDX_W-1:0]     idx, idx_q, idx_d;
   logic                 pred_q, pred_d;
   logic                 setflag_q, setflag_d;
   logic [CNT_WIDTH-1:0] br_count_q, br_count_d;
   logic [CNT_WIDTH-1:0] mispred_count_q, mispred_count_d;
   bht_cnt_t             rd_cnt;

   logic is_uncond, is_cond_br, is_br, cond_taken;
   logic valid_id, res;
   logic n, z, c, v;
   logic unused_bits;

   assign idx          = fetch_pc_i[IDX_LSB +: IDX_W];
   assign pred_taken_o = rd_cnt[1];
   assign unused_bits  = ^{fetch_pc_i, rd_cnt[0]};

   branch_hist_table #(.DEPTH(BHT_DEPTH)) u_bht (
      .clk_i     (clk_i),
      .reset_i   (reset_i),
      .rd_idx_i  (idx),
      .rd_cnt_o  (rd_cnt),
      .wr_en_i   (res),
      .wr_idx_i  (idx_q),
      .wr_taken_i(BrTaken_o)
   );

   // A flag-setting instruction one slot ahead is now in EX, so its flags
   // only exist on the ALU outputs and must be forwarded.
   assign n = setflag_q ? alu_neg_i   : flag_neg_i;
   assign z = setflag_q ? alu_zero_i  : flag_zero_i;
   assign c = setflag_q ? alu_cOut_i  : flag_cOut_i;
   assign v = setflag_q ? alu_overf_i : flag_overf_i;

   always_comb begin
      is_uncond  = 1'b0;
      is_cond_br = 1'b0;
      is_br      = 1'b0;
      cond_taken = 1'b0;
      casez (opcode_i)
         OP_B, OP_BL: is_uncond = 1'b1;
         OP_BCOND: begin
            is_cond_br = 1'b1;
            cond_taken = cond_holds(cond_i, n, z, c, v);
         end
         OP_CBZ: begin
            is_cond_br = 1'b1;
            cond_taken = (regVal_in_i == '0);
         end
         OP_CBNZ: begin
            is_cond_br = 1'b1;
            cond_taken = (regVal_in_i != '0);
         end
         OP_BR:   is_br = 1'b1;
         default: ;
      endcase
   end

   assign valid_id     = dec_valid_i && !flush_i;
   assign BrTaken_o    = valid_id && (is_uncond || (is_cond_br && cond_taken));
   assign UncondBr_o   = valid_id && is_uncond;
   assign pc_rd_o      = valid_id && is_br;
   // A stalled instruction will be presented again, so it resolves only once.
   assign res          = valid_id && !stall_i && is_cond_br;
   assign mispredict_o = res && (BrTaken_o != pred_q);

   assign br_count_o      = br_count_q;
   assign mispred_count_o = mispred_count_q;

   always_comb begin
      setflag_d = flag_wr_en_i && dec_valid_i && !stall_i && !flush_i;
      idx_d     = stall_i ? idx_q : idx;
      if (flush_i)      pred_d = 1'b0;
      else if (stall_i) pred_d = pred_q;
      else              pred_d = pred_taken_o;

      br_count_d      = br_count_q;
      mispred_count_d = mispred_count_q;
      if (res && (br_count_q != '1))
         br_count_d = br_count_q + CNT_WIDTH'(1);
      if (mispredict_o && (mispred_count_q != '1))
         mispred_count_d = mispred_count_q + CNT_WIDTH'(1);
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         pred_q          <= 1'b0;
         idx_q           <= '0;
         setflag_q       <= 1'b0;
         br_count_q      <= '0;
         mispred_count_q <= '0;
      end else begin
         pred_q          <= pred_d;
         idx_q           <= idx_d;
         setflag_q       <= setflag_d;
         br_count_q      <= br_count_d;
         mispred_count_q <= mispred_count_d;
      end
   end

endmodule
